// File: rtl/prog_load_controller_pkg.sv
// Shared system package for the program loader.
// Provides the loader FSM state encoding and the default width/depth constants
// used by prog_load_controller.
package prog_load_controller_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DONE = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/prog_load_controller.sv
// prog_load_controller: accepts a program image as a stream of valid/ready
// beats and writes it into program memory, then releases the CPU on request.
//
// Ports:
//   clock, reset_n        - rising-edge clock, async active-low reset
//   prog_valid/prog_ready - beat handshake (beat taken when both are 1)
//   prog_addr             - beat address (explicit mode, or base in auto-inc)
//   prog_data_in          - beat data
//   prog_last             - final beat of the image
//   auto_inc              - address mode, sampled on the first beat of an image
//   clear                 - synchronous return to IDLE, wipes status
//   start_execution       - request CPU run (honoured only in DONE)
//   mem_we/addr/wdata     - registered memory write port, one cycle per beat
//   load_done, load_error - image status flags
//   cpu_run               - CPU enable
//   checksum              - sum of written data mod 2**DATA_W
//   words_loaded          - written-beat count, saturating at 2**ADDR_W
module prog_load_controller
  import prog_load_controller_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data_in,
  input  logic              prog_last,
  input  logic              auto_inc,
  input  logic              clear,
  input  logic              start_execution,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_done,
  output logic              load_error,
  output logic              cpu_run,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   words_loaded
);

  // Addresses are carried one bit wider than the memory so an auto-increment
  // past the top of a full 2**ADDR_W memory is seen as out of range instead
  // of wrapping back to 0.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WL_MAX  = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t          state;
  logic            auto_mode;
  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] beat_addr;
  logic            accept;
  logic            in_range;

  assign prog_ready = ((state == ST_IDLE) || (state == ST_LOAD)) && !clear;
  assign accept     = prog_valid && prog_ready;

  // First beat of an image always uses prog_addr; later beats in auto-inc
  // mode follow the pointer and ignore prog_addr.
  always_comb begin
    beat_addr = {1'b0, prog_addr};
    if ((state == ST_LOAD) && auto_mode) beat_addr = ptr;
  end

  assign in_range = (beat_addr < DEPTH_L);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      auto_mode    <= 1'b0;
      ptr          <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      cpu_run      <= 1'b0;
      checksum     <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (clear) begin
        // prog_ready is low while clear is high, so no beat slips through.
        state        <= ST_IDLE;
        auto_mode    <= 1'b0;
        ptr          <= '0;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        cpu_run      <= 1'b0;
        checksum     <= '0;
        words_loaded <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_LOAD: begin
            if (accept) begin
              if (state == ST_IDLE) auto_mode <= auto_inc;
              if (in_range) begin
                mem_we    <= 1'b1;
                mem_addr  <= beat_addr[ADDR_W-1:0];
                mem_wdata <= prog_data_in;
                checksum  <= checksum + prog_data_in;
                if (words_loaded != WL_MAX) words_loaded <= words_loaded + ONE;
                ptr <= beat_addr + ONE;
                if (prog_last) begin
                  state     <= ST_DONE;
                  load_done <= 1'b1;
                end else begin
                  state <= ST_LOAD;
                end
              end else begin
                state      <= ST_ERR;
                load_error <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (start_execution) begin
              state   <= ST_RUN;
              cpu_run <= 1'b1;
            end
          end
          default: ; // RUN and ERR hold until clear or reset
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_load_controller.sv
// Directed bench for prog_load_controller. A DEPTH=32 instance carries most
// scenarios; a DEPTH=24 instance on the same inputs covers the short-memory
// range check.
module tb_prog_load_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       prog_valid = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data_in = '0;
  logic       prog_last = 1'b0;
  logic       auto_inc = 1'b0;
  logic       clear = 1'b0;
  logic       start_execution = 1'b0;

  logic       prog_ready, mem_we, load_done, load_error, cpu_run;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, checksum;
  logic [5:0] words_loaded;

  logic       prog_ready24, mem_we24, load_done24, load_error24, cpu_run24;
  logic [4:0] mem_addr24;
  logic [7:0] mem_wdata24, checksum24;
  logic [5:0] words_loaded24;

  int n_chk = 0;
  int n_fail = 0;
  logic [4:0] wa[$];
  logic [7:0] wd[$];
  int w24 = 0;

  always #5 clock = ~clock;

  prog_load_controller #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) u_dut (
    .clock(clock), .reset_n(reset_n), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_addr(prog_addr), .prog_data_in(prog_data_in), .prog_last(prog_last),
    .auto_inc(auto_inc), .clear(clear), .start_execution(start_execution),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_done(load_done), .load_error(load_error), .cpu_run(cpu_run),
    .checksum(checksum), .words_loaded(words_loaded));

  prog_load_controller #(.DATA_W(8), .ADDR_W(5), .DEPTH(24)) u_dut24 (
    .clock(clock), .reset_n(reset_n), .prog_valid(prog_valid), .prog_ready(prog_ready24),
    .prog_addr(prog_addr), .prog_data_in(prog_data_in), .prog_last(prog_last),
    .auto_inc(auto_inc), .clear(clear), .start_execution(start_execution),
    .mem_we(mem_we24), .mem_addr(mem_addr24), .mem_wdata(mem_wdata24),
    .load_done(load_done24), .load_error(load_error24), .cpu_run(cpu_run24),
    .checksum(checksum24), .words_loaded(words_loaded24));

  // Write monitor: mem_we is a single-cycle pulse, so each negedge sees it once.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_we24 === 1'b1) w24++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [4:0] a, input logic [7:0] d, input logic last, input logic ai);
    @(negedge clock);
    prog_valid = 1'b1; prog_addr = a; prog_data_in = d; prog_last = last; auto_inc = ai;
    @(posedge clock);
    #1 prog_valid = 1'b0; prog_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clock); start_execution = 1'b1;
    @(posedge clock); #1 start_execution = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
  endtask

  task automatic chk_wr(input int i, input logic [4:0] a, input logic [7:0] d);
    if (i < wa.size()) begin
      chk("wr_addr", 32'(wa[i]), 32'(a));
      chk("wr_data", 32'(wd[i]), 32'(d));
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_load_error", 32'(load_error), 0);
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_checksum", 32'(checksum), 0);
    chk("rst_words", 32'(words_loaded), 0);
    @(negedge clock); reset_n = 1'b1;
    idle(1);
    chk("idle_ready", 32'(prog_ready), 1);

    // Explicit 6-beat load, with start_execution pulsed mid-load
    beat(5'd16, 8'd42, 1'b0, 1'b0);
    beat(5'd17, 8'd24, 1'b0, 1'b0);
    pulse_start();
    chk("load_start_ignored", 32'(cpu_run), 0);
    beat(5'd0, 8'hC0, 1'b0, 1'b0);
    beat(5'd1, 8'hC1, 1'b0, 1'b0);
    beat(5'd2, 8'h28, 1'b0, 1'b0);
    beat(5'd3, 8'hF2, 1'b1, 1'b0);
    idle(1);
    chk("expl_writes", 32'(wa.size()), 6);
    chk_wr(0, 5'd16, 8'd42);
    chk_wr(1, 5'd17, 8'd24);
    chk_wr(2, 5'd0, 8'hC0);
    chk_wr(3, 5'd1, 8'hC1);
    chk_wr(4, 5'd2, 8'h28);
    chk_wr(5, 5'd3, 8'hF2);
    chk("expl_done", 32'(load_done), 1);
    chk("expl_checksum", 32'(checksum), 221);
    chk("expl_words", 32'(words_loaded), 6);

    // prog_valid held in DONE
    @(negedge clock);
    prog_valid = 1'b1; prog_addr = 5'd5; prog_data_in = 8'h33; prog_last = 1'b1;
    #1 chk("done_ready", 32'(prog_ready), 0);
    repeat (3) @(posedge clock);
    #1 prog_valid = 1'b0; prog_last = 1'b0;
    idle(1);
    chk("done_no_write", 32'(wa.size()), 6);
    chk("done_checksum", 32'(checksum), 221);

    // DONE -> RUN
    pulse_start();
    chk("run_cpu_run", 32'(cpu_run), 1);
    chk("run_load_done", 32'(load_done), 1);

    // clear wins over a simultaneous beat
    @(negedge clock);
    clear = 1'b1; prog_valid = 1'b1; prog_addr = 5'd2; prog_data_in = 8'h09; prog_last = 1'b1;
    #1 chk("clear_ready", 32'(prog_ready), 0);
    @(posedge clock);
    #1 clear = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    chk("clear_cpu_run", 32'(cpu_run), 0);
    chk("clear_load_done", 32'(load_done), 0);
    chk("clear_checksum", 32'(checksum), 0);
    chk("clear_words", 32'(words_loaded), 0);
    idle(2);
    chk("clear_no_write", 32'(wa.size()), 6);
    chk("clear_ready_after", 32'(prog_ready), 1);

    // Auto-increment from 29 runs off the end of a 32-word memory
    wa.delete(); wd.delete();
    beat(5'd29, 8'd1, 1'b0, 1'b1);
    beat(5'd3, 8'd2, 1'b0, 1'b1);
    beat(5'd3, 8'd3, 1'b0, 1'b1);
    beat(5'd3, 8'd4, 1'b1, 1'b1);
    idle(1);
    chk("auto_writes", 32'(wa.size()), 3);
    chk_wr(0, 5'd29, 8'd1);
    chk_wr(1, 5'd30, 8'd2);
    chk_wr(2, 5'd31, 8'd3);
    chk("auto_error", 32'(load_error), 1);
    chk("auto_done", 32'(load_done), 0);
    chk("auto_words", 32'(words_loaded), 3);
    chk("auto_checksum", 32'(checksum), 6);
    chk("err_ready", 32'(prog_ready), 0);
    pulse_start();
    chk("err_start_ignored", 32'(cpu_run), 0);
    do_clear();
    chk("err_clear", 32'(load_error), 0);

    // Address 24: out of range for DEPTH=24, in range for DEPTH=32
    wa.delete(); wd.delete(); w24 = 0;
    beat(5'd24, 8'h55, 1'b0, 1'b0);
    idle(1);
    chk("d24_no_write", 32'(w24), 0);
    chk("d24_error", 32'(load_error24), 1);
    chk("d24_ready", 32'(prog_ready24), 0);
    chk("d32_write", 32'(wa.size()), 1);
    chk("d32_no_error", 32'(load_error), 0);
    do_clear();

    // words_loaded saturates at 32
    for (int i = 0; i < 33; i++) beat(5'd0, 8'd1, (i == 32), 1'b0);
    idle(1);
    chk("sat_words", 32'(words_loaded), 32);
    chk("sat_checksum", 32'(checksum), 33);
    chk("sat_done", 32'(load_done), 1);
    do_clear();

    // Async reset mid-load
    beat(5'd3, 8'd9, 1'b0, 1'b0);
    beat(5'd4, 8'd10, 1'b0, 1'b0);
    chk("pre_rst_addr", 32'(mem_addr), 4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_we", 32'(mem_we), 0);
    chk("arst_mem_addr", 32'(mem_addr), 0);
    chk("arst_mem_wdata", 32'(mem_wdata), 0);
    chk("arst_checksum", 32'(checksum), 0);
    chk("arst_words", 32'(words_loaded), 0);
    chk("arst_flags", 32'({load_done, load_error, cpu_run}), 0);
    @(negedge clock); reset_n = 1'b1;
    wa.delete(); wd.delete();
    idle(3);
    chk("post_rst_no_write", 32'(wa.size()), 0);
    beat(5'd7, 8'h05, 1'b1, 1'b0);
    idle(1);
    chk("post_rst_done", 32'(load_done), 1);
    chk("post_rst_checksum", 32'(checksum), 5);
    chk("post_rst_writes", 32'(wa.size()), 1);
    chk_wr(0, 5'd7, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
